// File: rtl/capture_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package capture_pkg;

    localparam int unsigned DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StArmed   = 3'd2,
        StCapture = 3'd3,
        StFlush   = 3'd4,
        StHoldoff = 3'd5,
        StDone    = 3'd6
    } state_e;

endpackage

// File: rtl/capture_sequencer_if.sv
// ADC sample stream in and DMA stream out, as seen by the capture sequencer.
interface capture_sequencer_if;
    import capture_pkg::*;

    logic                  s_axis_tvalid;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  m_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

endinterface

// File: rtl/capture_skid.sv
// Hold register feeding an AXI-Stream output register; the hold slot lets the
// final beat of a shot be tagged with tlast once the shot is known to be over.
module capture_skid
    import capture_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  push,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ready,
    output logic                  drop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  last
);

    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  stall;
    logic                  move;

    assign stall = out_valid_q & ~ready;
    assign move  = (push | flush) & ~stall & hold_valid_q;
    assign drop  = push & stall;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        out_valid_d  = stall;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        if (move) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_last_d  = flush & ~push;
        end
        if (push && !stall) begin
            hold_valid_d = 1'b1;
            hold_data_d  = din;
        end else if (flush && move) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    assign valid = out_valid_q;
    assign dout  = out_data_q;
    assign last  = out_last_q;

endmodule

// File: rtl/capture_sequencer.sv
// Sequences ADC trigger clear/arm and forwards each triggered shot to the DMA
// as a length-limited, tlast-terminated AXI-Stream packet.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cfg_start,
    input  logic                       cfg_abort,
    input  logic [15:0]                cfg_trigger_level,
    input  logic [15:0]                cfg_shots,
    input  logic [31:0]                cfg_max_samples,
    input  logic [31:0]                cfg_holdoff,
    output logic [15:0]                trigger_level,
    output logic                       reset_trigger,
    output logic                       reset_max_sum,
    capture_sequencer_if.master        axis,
    output logic [2:0]                 state,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                shots_done,
    output logic [15:0]                overflow_count
);

    state_e      state_q, state_d;
    logic [15:0] shots_q;
    logic [31:0] max_q, holdoff_q;
    logic [31:0] beat_cnt_q, clr_cnt_q, wait_cnt_q;
    logic        abort_pend_q;
    logic        push, flush, drop, tlast_acc, cfg_ok, holdoff_end;

    assign cfg_ok      = (cfg_shots != 16'd0) && (cfg_max_samples != 32'd0);
    assign tlast_acc   = axis.m_axis_tvalid & axis.m_axis_tlast & axis.m_axis_tready;
    assign holdoff_end = (holdoff_q == 32'd0) || (wait_cnt_q == holdoff_q - 32'd1);

    // Abort wins over a coincident beat, so the packet closes on the held beat.
    always_comb begin
        push = 1'b0;
        flush = 1'b0;
        case (state_q)
            StArmed, StCapture: push = axis.s_axis_tvalid & ~cfg_abort;
            StFlush:            flush = 1'b1;
            default:            ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (!cfg_abort && cfg_start && cfg_ok) state_d = StClear;
            StDone: begin
                if (cfg_abort)                  state_d = StIdle;
                else if (cfg_start && cfg_ok)   state_d = StClear;
            end
            StClear: begin
                if (cfg_abort)                                  state_d = StIdle;
                else if (clr_cnt_q == 32'(CLEAR_CYCLES - 1))    state_d = StArmed;
            end
            StArmed: begin
                if (cfg_abort)                  state_d = StIdle;
                else if (axis.s_axis_tvalid)    state_d = (max_q == 32'd1) ? StFlush : StCapture;
            end
            StCapture: begin
                if (cfg_abort || !axis.s_axis_tvalid || (beat_cnt_q + 32'd1 == max_q))
                    state_d = StFlush;
            end
            StFlush: begin
                if (tlast_acc) state_d = (abort_pend_q || cfg_abort) ? StIdle : StHoldoff;
            end
            StHoldoff: begin
                if (cfg_abort)          state_d = StIdle;
                else if (holdoff_end)   state_d = (shots_done == shots_q) ? StDone : StClear;
            end
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= StIdle;
            trigger_level  <= '0;
            shots_q        <= '0;
            max_q          <= '0;
            holdoff_q      <= '0;
            beat_cnt_q     <= '0;
            clr_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            abort_pend_q   <= 1'b0;
            shots_done     <= '0;
            overflow_count <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            reset_trigger  <= 1'b1;
            reset_max_sum  <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= (state_q == StClear) ? clr_cnt_q + 32'd1 : 32'd0;
            wait_cnt_q <= (state_q == StHoldoff) ? wait_cnt_q + 32'd1 : 32'd0;

            if ((state_q == StIdle || state_q == StDone) && state_d == StClear) begin
                trigger_level  <= cfg_trigger_level;
                shots_q        <= cfg_shots;
                max_q          <= cfg_max_samples;
                holdoff_q      <= cfg_holdoff;
                shots_done     <= '0;
                overflow_count <= '0;
                abort_pend_q   <= 1'b0;
            end

            if (state_q == StArmed && push)   beat_cnt_q <= 32'd1;
            if (state_q == StCapture && push) beat_cnt_q <= beat_cnt_q + 32'd1;
            if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
            if ((state_q == StCapture || state_q == StFlush) && cfg_abort) abort_pend_q <= 1'b1;
            if (state_q == StFlush && tlast_acc) shots_done <= shots_done + 16'd1;

            busy          <= !(state_d == StIdle || state_d == StDone);
            done          <= (state_d == StDone);
            reset_trigger <= !(state_d == StArmed || state_d == StCapture);
            reset_max_sum <= (state_d == StIdle || state_d == StClear);
        end
    end

    assign state = state_q;

    capture_skid u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .flush   (flush),
        .din     (axis.s_axis_tdata),
        .ready   (axis.m_axis_tready),
        .drop    (drop),
        .valid   (axis.m_axis_tvalid),
        .dout    (axis.m_axis_tdata),
        .last    (axis.m_axis_tlast)
    );

endmodule
